// File: rtl/partial_sum_layer7.sv
// Layer-7 partial-sum stage.
//
// Each valid beat carries one signed decoded value per (channel, macro).
// Stage 1 reduces the macro values of every channel into a full-precision
// sum. Stage 2 accumulates ACC_NUM such beats per channel and publishes the
// result on data_out with a one-cycle data_e_out pulse.
//
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   data_e       - beat valid from the decoder
//   data_in      - [CHANNEL_NUM][MACRO_NUM] signed DECODER_O_DW values
//   acc_clr      - aborts the accumulation in progress (incl. beat in stage 1)
//   data_out     - [CHANNEL_NUM] signed PSUM_O_DW completed partial sums
//   data_e_out   - one-cycle pulse, data_out is new this cycle
//   busy         - a partial accumulation or a staged beat exists

// Per-channel datapath: macro reduction register, accumulator, output hold.
module partial_sum_layer7_lane #(
  parameter int MACRO_NUM    = 32,
  parameter int DECODER_O_DW = 4,
  parameter int PSUM_O_DW    = 16
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     en,        // stage-2 beat takes effect
  input  logic                                     cnt_zero,  // first beat of a result
  input  logic                                     cnt_last,  // last beat of a result
  input  logic [MACRO_NUM-1:0][DECODER_O_DW-1:0]   data_in,
  output logic [PSUM_O_DW-1:0]                     data_out
);
  // Exact width of a sum of MACRO_NUM signed DECODER_O_DW values.
  localparam int SUM_W = DECODER_O_DW + $clog2(MACRO_NUM);

  logic signed [SUM_W-1:0]     s1_sum_d, s1_sum_q;
  logic signed [PSUM_O_DW-1:0] acc_d, acc_q, out_d, out_q;
  logic signed [PSUM_O_DW-1:0] s1_ext, acc_plus;

  always_comb begin
    s1_sum_d = '0;
    for (int m = 0; m < MACRO_NUM; m++)
      s1_sum_d = s1_sum_d + SUM_W'($signed(data_in[m]));
  end

  assign s1_ext   = PSUM_O_DW'(s1_sum_q);
  assign acc_plus = acc_q + s1_ext;

  always_comb begin
    acc_d = acc_q;
    out_d = out_q;
    if (en) begin
      // First beat restarts the sum instead of adding to the finished one.
      acc_d = cnt_zero ? s1_ext : acc_plus;
      if (cnt_last) out_d = acc_plus;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_sum_q <= '0;
      acc_q    <= '0;
      out_q    <= '0;
    end else begin
      s1_sum_q <= s1_sum_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
    end
  end

  assign data_out = out_q;
endmodule

module partial_sum_layer7 #(
  parameter int CHANNEL_NUM  = 512,
  parameter int MACRO_NUM    = 32,
  parameter int ACC_NUM      = 16,
  parameter int DECODER_O_DW = 4,
  parameter int PSUM_O_DW    = 16
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic                                                    data_e,
  input  logic [CHANNEL_NUM-1:0][MACRO_NUM-1:0][DECODER_O_DW-1:0] data_in,
  input  logic                                                    acc_clr,
  output logic [CHANNEL_NUM-1:0][PSUM_O_DW-1:0]                   data_out,
  output logic                                                    data_e_out,
  output logic                                                    busy
);
  localparam int CW = $clog2(ACC_NUM);

  logic          s1_v_d, s1_v_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          data_e_out_d, data_e_out_q;
  logic          en, cnt_zero, cnt_last;

  // acc_clr kills both the incoming beat and the one already in stage 1.
  assign en       = s1_v_q & ~acc_clr;
  assign cnt_zero = (cnt_q == '0);
  assign cnt_last = (cnt_q == CW'(ACC_NUM - 1));

  always_comb begin
    s1_v_d       = data_e & ~acc_clr;
    cnt_d        = cnt_q;
    data_e_out_d = 1'b0;
    if (acc_clr) begin
      cnt_d = '0;
    end else if (s1_v_q) begin
      if (cnt_last) begin
        cnt_d        = '0;
        data_e_out_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q       <= 1'b0;
      cnt_q        <= '0;
      data_e_out_q <= 1'b0;
    end else begin
      s1_v_q       <= s1_v_d;
      cnt_q        <= cnt_d;
      data_e_out_q <= data_e_out_d;
    end
  end

  for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_lane
    partial_sum_layer7_lane #(
      .MACRO_NUM    (MACRO_NUM),
      .DECODER_O_DW (DECODER_O_DW),
      .PSUM_O_DW    (PSUM_O_DW)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .cnt_zero (cnt_zero),
      .cnt_last (cnt_last),
      .data_in  (data_in[c]),
      .data_out (data_out[c])
    );
  end

  assign data_e_out = data_e_out_q;
  assign busy       = (cnt_q != '0) | s1_v_q;
endmodule

// File: tb/tb_partial_sum_layer7.sv
module tb_partial_sum_layer7;
  localparam int CH = 512;
  localparam int MA = 32;
  localparam int AN = 16;
  localparam int DW = 4;
  localparam int OW = 16;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          data_e;
  logic [CH-1:0][MA-1:0][DW-1:0] data_in;
  logic                          acc_clr;
  logic [CH-1:0][OW-1:0]         data_out;
  logic                          data_e_out;
  logic                          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pulses  = 0;
  int last_pulse = 0;
  int busy_low = 0;
  int t1;

  partial_sum_layer7 #(
    .CHANNEL_NUM(CH), .MACRO_NUM(MA), .ACC_NUM(AN),
    .DECODER_O_DW(DW), .PSUM_O_DW(OW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_e(data_e), .data_in(data_in),
    .acc_clr(acc_clr), .data_out(data_out), .data_e_out(data_e_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (data_e_out) begin
      pulses++;
      last_pulse = cyc;
    end
    if (!busy) busy_low++;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_all(input int v);
    for (int c = 0; c < CH; c++)
      for (int m = 0; m < MA; m++)
        data_in[c][m] = DW'(v);
  endtask

  // Channel value pattern (c mod 8) - 4 on every macro.
  task automatic set_pattern();
    for (int c = 0; c < CH; c++)
      for (int m = 0; m < MA; m++)
        data_in[c][m] = DW'((c % 8) - 4);
  endtask

  // Compares all channels; reports the first mismatching channel (or ch 0).
  task automatic chk_all(input string tag, input bit pat, input int k);
    int idx;
    int e;
    idx = 0;
    for (int c = CH - 1; c >= 0; c--) begin
      e = pat ? ((c % 8) - 4) * k : k;
      if (int'($signed(data_out[c])) != e) idx = c;
    end
    e = pat ? ((idx % 8) - 4) * k : k;
    chk(tag, int'($signed(data_out[idx])), e);
  endtask

  task automatic beats(input int n, input int v);
    for (int i = 0; i < n; i++) begin
      data_e = 1'b1;
      set_all(v);
      tick();
    end
  endtask

  initial begin
    // Reset held two cycles with a live beat on the inputs.
    rst_n = 1'b0; data_e = 1'b1; acc_clr = 1'b0; set_all(7);
    tick();
    chk_all("reset_dout_c1", 0, 0);
    chk("reset_pulse_c1", int'(data_e_out), 0);
    chk("reset_busy_c1", int'(busy), 0);
    tick();
    chk_all("reset_dout_c2", 0, 0);
    chk("reset_busy_c2", int'(busy), 0);
    rst_n = 1'b1; data_e = 1'b0;
    tick();
    chk("post_reset_busy", int'(busy), 0);
    chk("post_reset_pulse", int'(data_e_out), 0);

    // Basic: 16 beats of 1 -> 512, pulse 2 cycles after the last beat.
    pulses = 0;
    beats(16, 1);
    data_e = 1'b0;
    chk("basic_no_early_pulse", pulses, 0);
    tick();
    chk("basic_pulse", int'(data_e_out), 1);
    chk_all("basic_dout", 0, 512);
    tick();
    chk("basic_pulse_one_cycle", int'(data_e_out), 0);
    chk_all("basic_dout_hold", 0, 512);

    // Signed extremes, back to back.
    pulses = 0;
    beats(16, -8);
    beats(1, 7);
    chk("neg_pulse", int'(data_e_out), 1);
    chk_all("neg_dout", 0, -4096);
    t1 = cyc;
    beats(15, 7);
    data_e = 1'b0;
    tick();
    chk("pos_pulse", int'(data_e_out), 1);
    chk_all("pos_dout", 0, 3584);
    chk("b2b_spacing", last_pulse - t1, 16);
    chk("b2b_pulse_count", pulses, 2);

    // Gaps of two idle cycles between beats.
    pulses = 0;
    beats(1, 2);
    busy_low = 0;
    for (int i = 1; i < 16; i++) begin
      data_e = 1'b0;
      tick();
      tick();
      beats(1, 2);
    end
    data_e = 1'b0;
    chk("gap_busy_held", busy_low, 0);
    chk("gap_no_early_pulse", pulses, 0);
    tick();
    chk("gap_pulse", pulses, 1);
    chk_all("gap_dout", 0, 1024);
    chk("gap_busy_done", int'(busy), 0);

    // Abort after 5 beats; the beat presented with acc_clr is dropped.
    pulses = 0;
    beats(5, 3);
    acc_clr = 1'b1; data_e = 1'b1; set_all(3);
    tick();
    acc_clr = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk_all("abort_dout_hold", 0, 1024);
    beats(16, 1);
    data_e = 1'b0;
    tick();
    tick();
    chk("abort_pulse_count", pulses, 1);
    chk_all("abort_dout", 0, 512);

    // Reset in the middle of an accumulation loses it, clears data_out.
    pulses = 0;
    beats(5, 1);
    rst_n = 1'b0; data_e = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_all("midreset_dout", 0, 0);
    chk("midreset_busy", int'(busy), 0);

    // Per-channel independence.
    for (int i = 0; i < 16; i++) begin
      data_e = 1'b1;
      set_pattern();
      tick();
    end
    data_e = 1'b0;
    tick();
    chk("chan_pulse", int'(data_e_out), 1);
    chk("chan_pulse_count", pulses, 1);
    chk_all("chan_dout", 1, 512);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
